// File: rtl/counter_pkg.sv
// Shared constants and helpers for the modulus up/down counter family.
package counter_pkg;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Bits needed to index v distinct values (parents sizing cascades).
  function automatic int clog2(input longint v);
    int     r;
    longint x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >>> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/mod_counter_next.sv
// Next-state logic for mod_updown_counter. MOD_COUNTER_SATURATE_EN selects
// hold-at-limit instead of wrap-around.
module mod_counter_next
  import counter_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] MAXV  = '1
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up_dn,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             at_max,
  input  logic             at_zero,
  output logic [WIDTH-1:0] next_count,
  output logic             next_wrap
);
  always_comb begin
    next_count = count;
    next_wrap  = 1'b0;
    if (clr) begin
      next_count = '0;
    end else if (load) begin
      next_count = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (at_max) begin
`ifdef MOD_COUNTER_SATURATE_EN
          next_count = MAXV;
`else
          next_count = '0;
          next_wrap  = 1'b1;
`endif
        end else begin
          next_count = count + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
`ifdef MOD_COUNTER_SATURATE_EN
          next_count = '0;
`else
          next_count = MAXV;
          next_wrap  = 1'b1;
`endif
        end else begin
          next_count = count - WIDTH'(1);
        end
      end
    end
  end
endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulus-N up/down counter with clear, clamped load, TC and WRAP.
// Define MOD_COUNTER_SATURATE_EN to saturate at the limits instead of wrapping.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic             UP_DN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] COUNT,
  output logic             TC,
  output logic             WRAP
);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  generate
    if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 ||
        MODULUS > (longint'(1) << WIDTH)) begin : g_bad_cfg
      $error("mod_updown_counter: illegal WIDTH/MODULUS combination");
    end
  endgenerate

  logic             at_max, at_zero;
  logic [WIDTH-1:0] next_count;
  logic             next_wrap;

  assign at_max  = (COUNT == MAXV);
  assign at_zero = (COUNT == '0);

  mod_counter_next #(.WIDTH(WIDTH), .MAXV(MAXV)) u_next (
    .count      (COUNT),
    .en         (EN),
    .up_dn      (UP_DN),
    .clr        (CLR),
    .load       (LOAD),
    .load_val   (LOAD_VAL),
    .at_max     (at_max),
    .at_zero    (at_zero),
    .next_count (next_count),
    .next_wrap  (next_wrap)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      COUNT <= '0;
      WRAP  <= 1'b0;
    end else begin
      COUNT <= next_count;
      WRAP  <= next_wrap;
    end
  end

  // Combinational so a cascaded stage sees it in the same cycle.
  assign TC = EN & ((UP_DN == DIR_DOWN) ? at_zero : at_max);
endmodule

// File: doc/mod_updown_counter.md
Name: mod_updown_counter

Overview:
Parametrised successor to the fixed 4-bit ripple counter, implemented as a fully synchronous counter.
- Configurable width and modulus.
- Up/down direction, count enable, synchronous clear and parallel load.
- Terminal-count and wrap outputs for cascading.
- Sits in the multiplier/sequencer datapath as the iteration and step counter; drives bit-serial multiplier cycle control.

Parameters:
- WIDTH, 4: COUNT width in bits. Range 1..32.
- MODULUS, 16: count range is 0..MODULUS-1. Constraint: 2 <= MODULUS <= 2^WIDTH; elaboration error otherwise.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-high reset; clears all state immediately.
- EN  input  1  count enable; counts one step per CLK edge when high.
- UP_DN  input  1  direction: 1 = up, 0 = down.
- CLR  input  1  synchronous clear to 0.
- LOAD  input  1  synchronous parallel load.
- LOAD_VAL  input  WIDTH  value used when LOAD is high.
- COUNT  output  WIDTH  registered count value.
- TC  output  1  combinational terminal count: EN high and COUNT at the terminal value for the current UP_DN.
- WRAP  output  1  registered one-cycle pulse, high in the cycle after COUNT wrapped.

Behaviour:
- Reset: RESET high asynchronously forces COUNT=0, WRAP=0. TC is therefore 0 unless EN=1 and UP_DN=0.
- Reset release: counting resumes on the first CLK edge after RESET falls. No extra latency cycle.
- Priority per edge, highest first: RESET > CLR > LOAD > EN. Lower-priority controls are ignored in the same cycle.
- CLR: COUNT<=0, WRAP<=0. CLR acts regardless of EN.
- LOAD: COUNT<=LOAD_VAL if LOAD_VAL < MODULUS, else COUNT<=MODULUS-1 (clamp). WRAP<=0. LOAD acts regardless of EN.
- Count up (EN=1, UP_DN=1):
  - COUNT<=COUNT+1.
  - At COUNT=MODULUS-1: COUNT<=0 and WRAP<=1.
- Count down (EN=1, UP_DN=0):
  - COUNT<=COUNT-1.
  - At COUNT=0: COUNT<=MODULUS-1 and WRAP<=1.
- Hold (EN=0, no CLR/LOAD): COUNT holds, WRAP<=0.
- Arithmetic: all compares and the increment/decrement use WIDTH bits; no intermediate overflow is permitted. When MODULUS=2^WIDTH, the wrap is the natural roll-over.
- TC:
  - Up: TC = EN & (COUNT==MODULUS-1).
  - Down: TC = EN & (COUNT==0).
  - TC is purely combinational and is used as the EN of the next cascaded stage.
- Direction change mid-count: takes effect on the next edge. No dead cycle. TC reflects the new direction immediately.
- RESET asserted mid-operation overrides everything at once; pending LOAD/CLR are discarded.

Optional Feature:
- Macro: MOD_COUNTER_SATURATE_EN.
- Defined:
  - No wrap. Up count holds at MODULUS-1; down count holds at 0.
  - WRAP is tied to 0.
  - TC is still asserted at the limit so upstream logic can stop issuing EN.
- Undefined: wrap-around behaviour as specified above.

Decomposition:
- Package counter_pkg:
  - Direction constants DIR_UP=1'b1, DIR_DOWN=1'b0.
  - Function clog2 for derived widths in parents.
- Sub-module mod_counter_next:
  - Combinational next-state logic.
  - Inputs: count, controls, terminal detection.
  - Outputs: next_count, next_wrap.
  - The top level keeps only registers and the TC assign.

Test Plan:
- Reset mid-count: WIDTH=4, MODULUS=10; count up to 6, pulse RESET for 5 ns between edges -> COUNT=0 immediately (async), WRAP=0; resumes 1,2,... after release.
- Up wrap: MODULUS=10, EN=1, UP_DN=1 from 0 -> COUNT 0..9. TC=1 while COUNT=9. Next edge COUNT=0 with WRAP=1 for exactly one cycle.
- Down wrap plus direction flip: load 2, UP_DN=0 -> 1, 0, 9 (WRAP pulse). Flip UP_DN=1 at COUNT=9 -> TC=1 immediately, next value 0.
- Priority: at COUNT=4, assert CLR, LOAD (LOAD_VAL=7) and EN together -> COUNT=0. Next cycle LOAD+EN only -> COUNT=7.
- Load clamp and hold: LOAD_VAL=13 with MODULUS=10 -> COUNT=9. EN=0 for 5 cycles -> COUNT stays 9, WRAP=0, TC=0.
- MOD_COUNTER_SATURATE_EN defined:
  - From 8 counting up -> 9, 9, 9; WRAP never 1; TC=1 while at 9.
  - Down from 1 -> 0, 0.
